// File: rtl/ride_mode_ctrl_pkg.sv
// ebike_pkg: shared types and constants for the rider-control front end.
//   press_state_t     : button press FSM states
//   BRK_ON_DEF/OFF_DEF: default brake thresholds, also used by the brushless tests
//   FAST_*            : shortened timing used when FAST_SIM is set
//   next_assist()     : assist level reached by a short press
package ebike_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    localparam logic [11:0] BRK_ON_DEF  = 12'h800;
    localparam logic [11:0] BRK_OFF_DEF = 12'h880;

    localparam int unsigned FAST_DB_CYCLES   = 16;
    localparam int unsigned FAST_LONG_CYCLES = 1024;

    // Off (0) is sticky for short presses; the top level wraps back to 1, skipping off.
    function automatic int unsigned next_assist(input int unsigned cur,
                                                input int unsigned num_modes);
        if (cur == 0) begin
            return 0;
        end else if (cur >= num_modes - 1) begin
            return 1;
        end else begin
            return cur + 1;
        end
    endfunction

endpackage

// File: rtl/ride_mode_ctrl_if.sv
// ride_mode_ctrl_if: rider-control bus.
//   tgglMd    : raw mode push-button (1 = pressed)
//   brake     : 12-bit brake A2D sample, valid when brake_vld is high
//   setting   : current mode (0 = off), mode_chg pulses when it changes
//   brake_n   : filtered brake (0 = braking), assist_en gates motor assist
// master drives the button/brake inputs; slave is the controller.
interface ride_mode_ctrl_if #(
    parameter int unsigned NUM_MODES = 4
) ();
    localparam int unsigned MODE_W = $clog2(NUM_MODES);

    logic              tgglMd;
    logic [11:0]       brake;
    logic              brake_vld;
    logic [MODE_W-1:0] setting;
    logic              mode_chg;
    logic              brake_n;
    logic              assist_en;

    modport master (
        output tgglMd, brake, brake_vld,
        input  setting, mode_chg, brake_n, assist_en
    );

    modport slave (
        input  tgglMd, brake, brake_vld,
        output setting, mode_chg, brake_n, assist_en
    );
endinterface

// File: rtl/ride_mode_ctrl_pb_debounce.sv
// pb_debounce: two-flop synchroniser plus debounce counter for a push-button.
//   clk, rst_n    : clock, async active-low reset
//   i_pb          : raw asynchronous button input
//   o_pb_stable   : debounced level; follows the synchronised input only after it has
//                   differed for DB_CYCLES consecutive cycles
module pb_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pb,
    output logic o_pb_stable
);
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       r_sync;
    logic             r_pb_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_pb_stable <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pb};
            if (r_sync[1] == r_pb_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_pb_stable <= r_sync[1];
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pb_stable = r_pb_stable;
endmodule

// File: rtl/ride_mode_ctrl.sv
// ride_mode_ctrl: rider-control front end.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   bus        : ride_mode_ctrl_if.slave (button, brake sample in; setting, mode_chg,
//                brake_n, assist_en out)
// Short press steps through assist levels 1..NUM_MODES-1, long press toggles off and
// back to the remembered level. Brake sample is filtered with hysteresis and a
// consecutive-sample release qualifier.
module ride_mode_ctrl
    import ebike_pkg::*;
#(
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned DEFAULT_MODE    = 2,
    parameter int unsigned DB_CYCLES       = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter logic [11:0] BRK_ON          = BRK_ON_DEF,
    parameter logic [11:0] BRK_OFF         = BRK_OFF_DEF,
    parameter int unsigned BRK_REL_SAMPLES = 4,
    parameter int unsigned FAST_SIM        = 0
) (
    input logic             clk,
    input logic             rst_n,
    ride_mode_ctrl_if.slave bus
);
    localparam int unsigned MODE_W   = $clog2(NUM_MODES);
    localparam int unsigned DB_EFF   = (FAST_SIM != 0) ? FAST_DB_CYCLES : DB_CYCLES;
    localparam int unsigned LONG_EFF = (FAST_SIM != 0) ? FAST_LONG_CYCLES : LONG_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(LONG_EFF + 1);
    localparam int unsigned REL_W    = $clog2(BRK_REL_SAMPLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_EFF - 1);
    localparam logic [REL_W-1:0]  REL_MAX  = REL_W'(BRK_REL_SAMPLES);

    logic w_pb_stable;

    press_state_t      r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              w_short, w_long;

    logic [MODE_W-1:0] r_setting, w_setting_nxt;
    logic [MODE_W-1:0] r_last, w_last_nxt;
    logic              r_mode_chg, w_mode_chg_nxt;

    logic              r_brake_n, w_brake_n_nxt;
    logic [REL_W-1:0]  r_rel, w_rel_nxt;
    logic              r_assist_en;

    pb_debounce #(
        .DB_CYCLES (DB_EFF)
    ) u_pb_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pb        (bus.tgglMd),
        .o_pb_stable (w_pb_stable)
    );

    // Press FSM: falling edge is checked before the hold limit so a release in the
    // same cycle as the long threshold counts as a short press.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short     = 1'b0;
        w_long      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pb_stable) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (!w_pb_stable) begin
                    w_short     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_hold == HOLD_MAX) begin
                    w_long      = 1'b1;
                    w_state_nxt = LONG_HELD;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!w_pb_stable) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_setting_nxt  = r_setting;
        w_last_nxt     = r_last;
        w_mode_chg_nxt = 1'b0;
        if (w_short && (r_setting != '0)) begin
            w_setting_nxt  = MODE_W'(next_assist(int'(r_setting), NUM_MODES));
            w_mode_chg_nxt = 1'b1;
        end else if (w_long) begin
            if (r_setting != '0) begin
                w_last_nxt    = r_setting;
                w_setting_nxt = '0;
            end else begin
                w_setting_nxt = r_last;
            end
            w_mode_chg_nxt = 1'b1;
        end
    end

    // Brake filter: any in-band or low sample breaks the release run.
    always_comb begin
        w_brake_n_nxt = r_brake_n;
        w_rel_nxt     = r_rel;
        if (bus.brake_vld) begin
            if (bus.brake < BRK_ON) begin
                w_brake_n_nxt = 1'b0;
                w_rel_nxt     = '0;
            end else if (bus.brake >= BRK_OFF) begin
                if (r_rel != REL_MAX) begin
                    w_rel_nxt = r_rel + REL_W'(1);
                end
                if (w_rel_nxt == REL_MAX) begin
                    w_brake_n_nxt = 1'b1;
                end
            end else begin
                w_rel_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_setting   <= MODE_W'(DEFAULT_MODE);
            r_last      <= MODE_W'(DEFAULT_MODE);
            r_mode_chg  <= 1'b0;
            r_brake_n   <= 1'b0;
            r_rel       <= '0;
            r_assist_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_setting   <= w_setting_nxt;
            r_last      <= w_last_nxt;
            r_mode_chg  <= w_mode_chg_nxt;
            r_brake_n   <= w_brake_n_nxt;
            r_rel       <= w_rel_nxt;
            r_assist_en <= r_brake_n && (r_setting != '0);
        end
    end

    assign bus.setting   = r_setting;
    assign bus.mode_chg  = r_mode_chg;
    assign bus.brake_n   = r_brake_n;
    assign bus.assist_en = r_assist_en;
endmodule

// File: tb/tb_ride_mode_ctrl.sv
// Testbench for ride_mode_ctrl with FAST_SIM timing (debounce 16, long press 1024).
module tb_ride_mode_ctrl;
    localparam int NUM_MODES = 4;
    localparam int PB_LAT    = 18;    // raw edge to debounced edge: 2 sync + 16 debounce
    localparam int LONG_EDGE = 1043;  // raw press to long-action edge: 18 + 1 + 1024
    localparam int BRK_ON    = 'h800;
    localparam int BRK_OFF   = 'h880;

    logic clk;
    logic rst_n;

    ride_mode_ctrl_if #(.NUM_MODES(NUM_MODES)) bus ();

    ride_mode_ctrl #(
        .NUM_MODES (NUM_MODES),
        .FAST_SIM  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_setting;
    int m_last;
    int m_brake_n;
    int exp_chg;
    int hist[$];

    int chg_seen = 0;
    always @(posedge clk) begin
        if (bus.mode_chg === 1'b1) chg_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_setting = 2;
        m_last    = 2;
        m_brake_n = 0;
        hist.delete();
    endtask

    task automatic model_short();
        if (m_setting != 0) begin
            m_setting = (m_setting % (NUM_MODES - 1)) + 1;
            exp_chg++;
        end
    endtask

    task automatic model_long();
        if (m_setting != 0) begin
            m_last    = m_setting;
            m_setting = 0;
        end else begin
            m_setting = m_last;
        end
        exp_chg++;
    endtask

    // Released only when the last four samples are all at or above the release level.
    task automatic model_brake(input int val);
        bit all_high;
        hist.push_back(val);
        if (hist.size() > 4) void'(hist.pop_front());
        if (val < BRK_ON) begin
            m_brake_n = 0;
        end else begin
            all_high = (hist.size() == 4);
            foreach (hist[i]) if (hist[i] < BRK_OFF) all_high = 0;
            if (all_high) m_brake_n = 1;
        end
    endtask

    function automatic int exp_assist();
        return (m_brake_n != 0 && m_setting != 0) ? 1 : 0;
    endfunction

    task automatic press(input int hold);
        int old;
        old = m_setting;
        bus.tgglMd = 1'b1;
        if (hold >= LONG_EDGE) begin
            repeat (LONG_EDGE - 1) tick();
            check("long_pre", bus.setting, old);
            tick();
            model_long();
            check("long_set", bus.setting, m_setting);
            check("long_chg", bus.mode_chg, 1);
            tick();
            check("long_chg_end", bus.mode_chg, 0);
            check("long_assist", bus.assist_en, exp_assist());
            repeat (hold - LONG_EDGE - 1) tick();
            bus.tgglMd = 1'b0;
            repeat (PB_LAT + 5) tick();
            check("long_release", bus.setting, m_setting);
        end else begin
            repeat (hold) tick();
            bus.tgglMd = 1'b0;
            repeat (PB_LAT) tick();
            check("short_pre", bus.setting, old);
            tick();
            model_short();
            check("short_set", bus.setting, m_setting);
            check("short_chg", bus.mode_chg, (old != 0) ? 1 : 0);
            tick();
            check("short_chg_end", bus.mode_chg, 0);
            check("short_assist", bus.assist_en, exp_assist());
        end
        check("chg_count", chg_seen, exp_chg);
    endtask

    task automatic glitch(input int len, input int gap);
        bus.tgglMd = 1'b1;
        repeat (len) tick();
        bus.tgglMd = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic brake_sample(input int val, input int gap);
        bus.brake     = 12'(val);
        bus.brake_vld = 1'b1;
        tick();
        bus.brake_vld = 1'b0;
        model_brake(val);
        check("brake_n", bus.brake_n, m_brake_n);
        tick();
        check("brake_assist", bus.assist_en, exp_assist());
        repeat (gap) tick();
    endtask

    function automatic int rand_brake();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, BRK_ON - 1);
            1:       return $urandom_range(BRK_ON, BRK_OFF - 1);
            2:       return $urandom_range(BRK_OFF, 'hFFF);
            default: return $urandom_range(BRK_OFF, BRK_OFF + 4);
        endcase
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.tgglMd    = 1'b0;
        bus.brake     = '0;
        bus.brake_vld = 1'b0;
        exp_chg       = 0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_setting", bus.setting, 2);
        check("rst_brake_n", bus.brake_n, 0);
        check("rst_assist", bus.assist_en, 0);
        check("rst_mode_chg", bus.mode_chg, 0);

        // Qualified brake release
        repeat (4) brake_sample('h900, 0);
        check("release_brake_n", bus.brake_n, 1);
        check("release_assist", bus.assist_en, 1);

        // Three short presses: 2 -> 3 -> 1 -> 2
        repeat (3) begin
            press(100);
            repeat (10) tick();
        end
        check("short_seq_end", bus.setting, 2);

        // Glitches shorter than the debounce window
        for (int i = 0; i < 6; i++) glitch(5, 8);
        repeat (40) tick();
        check("glitch_setting", bus.setting, m_setting);
        check("glitch_chg", chg_seen, exp_chg);

        // Long press at 3 -> off, short ignored while off, long press -> 3
        press(100);
        check("pre_long", bus.setting, 3);
        press(1100);
        check("long_off", bus.setting, 0);
        press(100);
        check("short_ignored", bus.setting, 0);
        press(1100);
        check("long_restore", bus.setting, 3);

        // Brake sequence with hysteresis band
        repeat (4) brake_sample('h900, 0);
        brake_sample('h7FF, 1);
        repeat (5) brake_sample('h850, 0);
        repeat (3) brake_sample('h900, 2);
        check("brake_seq_end", bus.brake_n, 0);

        // Randomised mix of presses, glitches and brake bursts
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: press($urandom_range(20, 900));
                1: press($urandom_range(1100, 1300));
                2: begin
                    glitch($urandom_range(1, 10), $urandom_range(1, 12));
                    repeat (30) tick();
                    check("rnd_glitch", bus.setting, m_setting);
                end
                default: begin
                    for (int k = 0; k < int'($urandom_range(1, 8)); k++)
                        brake_sample(rand_brake(), $urandom_range(0, 3));
                end
            endcase
            repeat ($urandom_range(2, 20)) tick();
        end
        check("rnd_chg_count", chg_seen, exp_chg);

        // Async reset in the middle of a long press
        bus.tgglMd = 1'b1;
        repeat (PB_LAT + 1 + 500) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_setting", bus.setting, 2);
        check("midrst_brake_n", bus.brake_n, 0);
        check("midrst_assist", bus.assist_en, 0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();  // still held, but not long enough to requalify
        bus.tgglMd = 1'b0;
        repeat (LONG_EDGE + 20) tick();
        check("midrst_hold", bus.setting, 2);
        check("midrst_chg", chg_seen, exp_chg);
        press(100);
        check("post_rst_press", bus.setting, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ride_mode_ctrl.md
# ride_mode_ctrl

Parametrised rider-control front end for the eBike top level. It replaces the fixed 2-bit toggle counter and single-threshold brake compare. It debounces the mode push-button, separates short and long presses, and manages N assist levels with an "off" memory. It also filters the brake A2D reading with hysteresis and a release qualifier. Outputs feed sensorCondition (`setting`), brushless (`brake_n`) and the assist-gating logic (`assist_en`).

## Interface
- NUM_MODES, 4, number of setting codes; 0 = off, 1..NUM_MODES-1 = assist levels (min 3)
- DEFAULT_MODE, 2, setting after reset; must be in 1..NUM_MODES-1
- DB_CYCLES, 1_000_000, debounce qualification length in clk cycles (20 ms @ 50 MHz)
- LONG_CYCLES, 50_000_000, hold time that defines a long press (1 s)
- BRK_ON, 12'h800, brake asserted when sample < BRK_ON
- BRK_OFF, 12'h880, release threshold; must be ≥ BRK_ON
- BRK_REL_SAMPLES, 4, consecutive samples ≥ BRK_OFF needed to release
- FAST_SIM, 0, when 1: DB_CYCLES→16, LONG_CYCLES→1024
- MODE_W (localparam) = $clog2(NUM_MODES)

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  reset, asynchronous, active-low
- tgglMd  in  1  raw push-button, asynchronous, 1 = pressed
- brake  in  12  brake A2D reading
- brake_vld  in  1  one-cycle strobe; `brake` is valid this cycle
- setting  out  MODE_W  current mode
- mode_chg  out  1  one-cycle pulse, high in the first cycle the new `setting` is visible
- brake_n  out  1  0 = braking
- assist_en  out  1  registered: brake_n && setting != 0

## Operation
- Button synchroniser: 2 flops, reset 0.
- Debounce: `pb_stable` (reset 0) takes the synchronised value only after it differs from `pb_stable` for DB_CYCLES consecutive cycles. The counter clears whenever the two are equal.
- Press FSM, states IDLE / PRESSED / LONG_HELD; reset IDLE.
  - IDLE: `pb_stable` rises → PRESSED; hold counter cleared.
  - PRESSED: `pb_stable` falls before the hold counter reaches LONG_CYCLES-1 → short action, then IDLE. Hold counter reaches LONG_CYCLES-1 → long action, then LONG_HELD. If both occur in the same cycle, the short action wins.
  - LONG_HELD: `pb_stable` falls → IDLE, no action. Holding longer produces no further actions.
- Short action:
  - setting in 1..NUM_MODES-2 → setting+1.
  - setting = NUM_MODES-1 → 1 (wrap skips off).
  - setting = 0 → ignored, no `mode_chg`.
- Long action:
  - setting ≠ 0 → last_mode := setting, setting := 0.
  - setting = 0 → setting := last_mode.
  - last_mode resets to DEFAULT_MODE.
- Brake filter, acting only on `brake_vld` cycles:
  - sample < BRK_ON → brake_n := 0, release counter cleared.
  - sample ≥ BRK_OFF → release counter +1 (saturating); when it reaches BRK_REL_SAMPLES, brake_n := 1.
  - Hysteresis band (BRK_ON ≤ sample < BRK_OFF) → brake_n holds, release counter cleared.
- Reset values: setting = DEFAULT_MODE, mode_chg = 0, brake_n = 0 (braked until qualified release), assist_en = 0.

## Timing
- Button: a raw edge reaches `pb_stable` 2 + DB_CYCLES cycles later, provided the input stays stable.
- Short action: `setting` and `mode_chg` update 1 cycle after the falling edge of `pb_stable`.
- Long action: `setting` updates 1 cycle after the hold counter reaches LONG_CYCLES-1, i.e. while the button is still held.
- Brake assert: `brake_n` falls 1 cycle after a `brake_vld` with a sample < BRK_ON.
- Brake release: `brake_n` rises 1 cycle after the BRK_REL_SAMPLES-th consecutive qualifying `brake_vld`.
- `assist_en`: follows its inputs with 1 cycle latency.
- Bounces shorter than DB_CYCLES are never seen by the FSM.
- Async reset mid-press: the FSM returns to IDLE and `pb_stable` to 0. A button still held after reset must qualify a fresh rise before any action.
- Counters saturate and never wrap.

## Structure
- `ebike_pkg`: `press_state_t` enum {IDLE, PRESSED, LONG_HELD}; brake threshold defaults BRK_ON_DEF / BRK_OFF_DEF shared with the brushless tests.
- One sub-module: `pb_debounce` (synchroniser + debounce counter, parameter DB_CYCLES, output `pb_stable`). Instantiated once.
- eBike top-level integration: replace the inline setting counter and brake compare with this block.

## Test plan
- FAST_SIM=1, reset → setting=2, brake_n=0, assist_en=0. Four brake_vld strobes with brake=12'h900 → brake_n=1 after the 4th; assist_en=1 one cycle later.
- Three short presses (held 100 cycles each) from setting=2 → 3, 1, 2; one `mode_chg` pulse per press.
- 5-cycle glitches on tgglMd → setting unchanged, no `mode_chg`.
- Long press (1100 cycles) at setting=3 → setting=0 at hold cycle ~1040, nothing on release. Second long press → setting=3. Short press while at 0 → ignored.
- Brake sequence 12'h900 ×4, 12'h7FF, 12'h850 ×5, 12'h900 ×3 → brake_n 1, then 0, then stays 0 (band and fewer than 4 qualifying samples).
- rst_n asserted mid-long-press at hold cycle 500 → setting=2, FSM IDLE. Button still held after reset → no action until release and a new press.
